// File: rtl/scan_ram_if.sv
// Bus bundle for scan_ram: write port, random read port and scan stream.
interface scan_ram_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             scan_start;
  logic [AW-1:0]    scan_base;
  logic [AW:0]      scan_len;
  logic             scan_abort;
  logic [WIDTH-1:0] scan_data;
  logic             scan_valid;
  logic             scan_ready;
  logic             scan_busy;
  logic             scan_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
           scan_start, scan_base, scan_len, scan_abort, scan_ready,
    input  rd_data, rd_valid, scan_data, scan_valid, scan_busy, scan_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
           scan_start, scan_base, scan_len, scan_abort, scan_ready,
    output rd_data, rd_valid, scan_data, scan_valid, scan_busy, scan_done
  );
endinterface

// File: rtl/scan_ram.sv
// Pattern-initialised RAM with a 1-cycle random read port and a
// valid/ready scan engine streaming a wrapping contiguous address range.
module scan_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input logic      clk,
  input logic      rst_n,
  scan_ram_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  state_t           state;
  logic [AW-1:0]    ptr;
  logic [AW:0]      rem;
  logic [WIDTH-1:0] rd_data_q, scan_data_q;
  logic             rd_valid_q, scan_valid_q, scan_busy_q, scan_done_q;
  logic             beat, load;

  // Array is reset to the i+1 ramp with an all-ones top word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i == DEPTH-1) ? {WIDTH{1'b1}} : WIDTH'(i + 1);
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Non-blocking reads below see pre-write contents: read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];
    end
  end

  assign beat = scan_valid_q && bus.scan_ready;
  assign load = (!scan_valid_q || bus.scan_ready) && (rem != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      rem          <= '0;
      scan_data_q  <= '0;
      scan_valid_q <= 1'b0;
      scan_busy_q  <= 1'b0;
      scan_done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          scan_done_q <= 1'b0;
          if (bus.scan_start) begin
            if (bus.scan_len != '0) begin
              // First word is fetched on the start edge so it is valid next cycle.
              state        <= RUN;
              scan_busy_q  <= 1'b1;
              scan_data_q  <= mem[bus.scan_base];
              scan_valid_q <= 1'b1;
              ptr          <= bus.scan_base + 1'b1;
              rem          <= bus.scan_len - 1'b1;
            end else begin
              state       <= DONE;
              scan_done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.scan_abort) begin
            state        <= IDLE;
            scan_valid_q <= 1'b0;
            scan_busy_q  <= 1'b0;
          end else if (beat && rem == '0) begin
            state        <= DONE;
            scan_valid_q <= 1'b0;
            scan_busy_q  <= 1'b0;
            scan_done_q  <= 1'b1;
          end else if (load) begin
            scan_data_q  <= mem[ptr];
            scan_valid_q <= 1'b1;
            ptr          <= ptr + 1'b1;
            rem          <= rem - 1'b1;
          end
        end
        DONE: begin
          scan_done_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.scan_data  = scan_data_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.scan_busy  = scan_busy_q;
  assign bus.scan_done  = scan_done_q;
endmodule

// File: tb/tb_scan_ram.sv
// Randomised self-checking bench for scan_ram against an array/queue model.
module tb_scan_ram;
  localparam int W = 16;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass = 0;
  int   total = 0;
  logic [W-1:0] mdl [D];

  scan_ram_if #(.WIDTH(W), .DEPTH(D)) bus ();
  scan_ram #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) mdl[i] = (i == D-1) ? 16'hFFFF : 16'(i + 1);
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.rd_en = 0; bus.rd_addr = 0;
    bus.scan_start = 0; bus.scan_base = 0; bus.scan_len = 0;
    bus.scan_abort = 0; bus.scan_ready = 0;
    #3;
    total++;
    if (bus.rd_data !== 0 || bus.rd_valid !== 0 || bus.scan_data !== 0 ||
        bus.scan_valid !== 0 || bus.scan_busy !== 0 || bus.scan_done !== 0)
      $display("FAIL reset_outputs: rd=%h rv=%b sd=%h sv=%b busy=%b done=%b, want all 0",
               bus.rd_data, bus.rd_valid, bus.scan_data, bus.scan_valid, bus.scan_busy, bus.scan_done);
    else pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_init_read();
    logic [W-1:0] exp;
    for (int i = 0; i < D; i++) begin
      bus.rd_en = 1; bus.rd_addr = 4'(i);
      step();
      exp = (i == D-1) ? 16'hFFFF : 16'(i + 1);
      total++;
      if (bus.rd_valid !== 1 || bus.rd_data !== exp)
        $display("FAIL init_read[%0d]: got %h valid=%b, want %h valid=1", i, bus.rd_data, bus.rd_valid, exp);
      else pass++;
    end
    bus.rd_en = 0;
    step();
    total++;
    if (bus.rd_valid !== 0 || bus.rd_data !== 16'hFFFF)
      $display("FAIL read_hold: got %h valid=%b, want FFFF valid=0", bus.rd_data, bus.rd_valid);
    else pass++;
  endtask

  task automatic test_rbw();
    bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 16'hA5A5;
    bus.rd_en = 1; bus.rd_addr = 3;
    step();
    bus.wr_en = 0;
    mdl[3] = 16'hA5A5;
    total++;
    if (bus.rd_data !== 16'h0004)
      $display("FAIL rbw_old: got %h, want 0004", bus.rd_data);
    else pass++;
    step();
    bus.rd_en = 0;
    total++;
    if (bus.rd_data !== 16'hA5A5)
      $display("FAIL rbw_new: got %h, want A5A5", bus.rd_data);
    else pass++;
  endtask

  // rmode: 0 ready held high, 1 random ready (+ ignored starts), 2 ready pattern 1-0-0-1
  task automatic do_scan(input int base, input int len, input int rmode, input int abort_after);
    logic [W-1:0] q[$];
    logic [W-1:0] hold_d, exp;
    bit hold, rdy, fin;
    int beats;
    for (int k = 0; k < len; k++) q.push_back(mdl[(base + k) % D]);
    bus.scan_base = 4'(base); bus.scan_len = 5'(len); bus.scan_start = 1;
    step();
    bus.scan_start = 0;
    if (len == 0) begin
      total++;
      if (bus.scan_done !== 1 || bus.scan_valid !== 0 || bus.scan_busy !== 0)
        $display("FAIL scan_zero: done=%b valid=%b busy=%b, want 1 0 0", bus.scan_done, bus.scan_valid, bus.scan_busy);
      else pass++;
      step();
      total++;
      if (bus.scan_done !== 0 || bus.scan_valid !== 0 || bus.scan_busy !== 0)
        $display("FAIL scan_zero_after: done=%b valid=%b busy=%b, want 0 0 0", bus.scan_done, bus.scan_valid, bus.scan_busy);
      else pass++;
      return;
    end
    hold = 0; fin = 0; beats = 0; hold_d = '0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      total++;
      if (bus.scan_busy !== 1 || bus.scan_done !== 0 || bus.scan_valid !== 1 ||
          (hold && bus.scan_data !== hold_d))
        $display("FAIL scan_run: busy=%b done=%b valid=%b data=%h, want 1 0 1 held=%b %h",
                 bus.scan_busy, bus.scan_done, bus.scan_valid, bus.scan_data, hold, hold_d);
      else pass++;
      if (abort_after >= 0 && beats == abort_after) begin
        bus.scan_abort = 1; bus.scan_ready = 1;
        step();
        bus.scan_abort = 0; bus.scan_ready = 0;
        total++;
        if (bus.scan_valid !== 0 || bus.scan_busy !== 0 || bus.scan_done !== 0)
          $display("FAIL scan_abort: valid=%b busy=%b done=%b, want 0 0 0", bus.scan_valid, bus.scan_busy, bus.scan_done);
        else pass++;
        step();
        total++;
        if (bus.scan_valid !== 0 || bus.scan_busy !== 0 || bus.scan_done !== 0)
          $display("FAIL scan_abort_after: valid=%b busy=%b done=%b, want 0 0 0", bus.scan_valid, bus.scan_busy, bus.scan_done);
        else pass++;
        return;
      end
      case (rmode)
        0:       rdy = 1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      bus.scan_ready = rdy;
      if (rmode == 1) begin
        bus.scan_start = 1'($urandom_range(0, 1));
        bus.scan_len = 0;
        bus.scan_base = 4'($urandom);
      end
      if (rdy) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL scan_extra_beat: got %h, want no beat", bus.scan_data);
        end else begin
          exp = q.pop_front();
          if (bus.scan_data !== exp)
            $display("FAIL scan_data[%0d]: got %h, want %h", beats, bus.scan_data, exp);
          else pass++;
        end
        beats++;
      end
      hold = !rdy;
      hold_d = bus.scan_data;
      step();
      bus.scan_start = 0;
      if (rdy && q.size() == 0) begin
        total++;
        if (bus.scan_done !== 1 || bus.scan_valid !== 0 || bus.scan_busy !== 0)
          $display("FAIL scan_done: done=%b valid=%b busy=%b, want 1 0 0", bus.scan_done, bus.scan_valid, bus.scan_busy);
        else pass++;
        step();
        total++;
        if (bus.scan_done !== 0 || bus.scan_busy !== 0)
          $display("FAIL scan_done_pulse: done=%b busy=%b, want 0 0", bus.scan_done, bus.scan_busy);
        else pass++;
        fin = 1;
      end
    end
    if (!fin) begin
      total++;
      $display("FAIL scan_timeout: %0d beats left, want 0", q.size());
    end
    bus.scan_ready = 0;
  endtask

  task automatic test_scan_wrap();
    do_scan(14, 4, 0, -1);
  endtask

  task automatic test_scan_stall();
    do_scan(0, 3, 2, -1);
  endtask

  task automatic test_scan_zero();
    do_scan(5, 0, 0, -1);
  endtask

  task automatic test_scan_abort();
    do_scan(4, 8, 0, 2);
    do_scan(9, 5, 0, -1);
  endtask

  task automatic test_random_rw();
    logic [W-1:0] exp_d;
    bit exp_v;
    int ra;
    exp_d = '0;
    for (int n = 0; n < 150; n++) begin
      bus.wr_en   = 1'($urandom_range(0, 1));
      bus.wr_addr = 4'($urandom);
      bus.wr_data = 16'($urandom);
      exp_v       = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ra          = $urandom_range(0, D-1);
      bus.rd_en   = exp_v;
      bus.rd_addr = 4'(ra);
      if (exp_v) exp_d = mdl[ra];
      if (bus.wr_en) mdl[bus.wr_addr] = bus.wr_data;
      step();
      total++;
      if (bus.rd_valid !== exp_v || bus.rd_data !== exp_d)
        $display("FAIL random_rw[%0d]: got %h valid=%b, want %h valid=%b", n, bus.rd_data, bus.rd_valid, exp_d, exp_v);
      else pass++;
    end
    bus.wr_en = 0; bus.rd_en = 0;
    step();
  endtask

  task automatic test_scan_random();
    for (int n = 0; n < 8; n++)
      do_scan($urandom_range(0, D-1), $urandom_range(0, 2*D-1), 1, -1);
  endtask

  task automatic test_reset_midscan();
    bus.rd_en = 1; bus.rd_addr = 15;
    bus.scan_base = 0; bus.scan_len = 8; bus.scan_start = 1; bus.scan_ready = 0;
    step();
    bus.rd_en = 0; bus.scan_start = 0;
    step();
    total++;
    if (bus.scan_valid !== 1 || bus.scan_busy !== 1 || bus.rd_data !== mdl[15])
      $display("FAIL midscan_pre: valid=%b busy=%b rd=%h, want 1 1 %h", bus.scan_valid, bus.scan_busy, bus.rd_data, mdl[15]);
    else pass++;
    #2 rst_n = 0;
    #1;
    total++;
    if (bus.rd_data !== 0 || bus.rd_valid !== 0 || bus.scan_data !== 0 ||
        bus.scan_valid !== 0 || bus.scan_busy !== 0 || bus.scan_done !== 0)
      $display("FAIL midscan_reset: rd=%h rv=%b sd=%h sv=%b busy=%b done=%b, want all 0",
               bus.rd_data, bus.rd_valid, bus.scan_data, bus.scan_valid, bus.scan_busy, bus.scan_done);
    else pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    bus.rd_en = 1; bus.rd_addr = 3; bus.scan_ready = 1;
    step();
    bus.rd_en = 0;
    total++;
    if (bus.rd_data !== 16'h0004 || bus.scan_done !== 0 || bus.scan_valid !== 0)
      $display("FAIL post_reset: rd=%h done=%b sv=%b, want 0004 0 0", bus.rd_data, bus.scan_done, bus.scan_valid);
    else pass++;
    bus.scan_ready = 0;
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_rbw();
    test_scan_wrap();
    test_scan_stall();
    test_scan_zero();
    test_scan_abort();
    test_random_rw();
    test_scan_random();
    test_reset_midscan();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
